// File: rtl/paralelo_serial_tx_pkg.sv
// Shared constants and types for the PHY TX lane byte-to-serial transmitter.
package paralelo_serial_tx_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  // Comma / idle character and default number of post-reset commas.
  localparam logic [BYTE_W-1:0] IDLE_CHAR_DEF = 8'hBC;
  localparam int unsigned       N_SYNC_DEF    = 4;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/paralelo_serial_tx_if.sv
// Byte source handshake into the transmitter holding buffer.
interface paralelo_serial_tx_if;
  import paralelo_serial_tx_pkg::*;

  logic [BYTE_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);

endinterface

// File: rtl/tx_shift8.sv
// Bit counter, load-edge generation and MSB-first shift register.
module tx_shift8
  import paralelo_serial_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] load_data,
  output logic              load_c,
  output logic              data_out,
  output logic              byte_strobe
);

  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    sh_q, sh_d;
  logic                 strobe_q, strobe_d;

  // Load on the wrap edge, otherwise shift left filling with zero.
  always_comb begin
    load_c    = (bit_cnt_q == BIT_CNT_W'(7));
    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    sh_d      = {sh_q[BYTE_W-2:0], 1'b0};
    strobe_d  = 1'b0;
    if (load_c) begin
      sh_d     = load_data;
      strobe_d = 1'b1;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      sh_q      <= '0;
      strobe_q  <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      strobe_q  <= strobe_d;
    end
  end

  assign data_out    = sh_q[BYTE_W-1];
  assign byte_strobe = strobe_q;

endmodule

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial TX lane: post-reset comma sync, holding buffer, idle fill.
module paralelo_serial_tx
  import paralelo_serial_tx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] IDLE_CHAR = IDLE_CHAR_DEF,
  parameter int unsigned       N_SYNC    = N_SYNC_DEF
) (
  input  logic                      clk_32f,
  input  logic                      reset_L,
  paralelo_serial_tx_if.slave       bus,
  output logic                      data_out,
  output logic                      byte_strobe,
  output logic                      sync_done
);

  localparam int unsigned             SYNC_CNT_W = cnt_width(N_SYNC);
  localparam logic [SYNC_CNT_W-1:0]   SYNC_LAST  = SYNC_CNT_W'(N_SYNC - 1);

  tx_state_e               state_q, state_d;
  logic [SYNC_CNT_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic                    hold_full_q, hold_full_d;
  logic [BYTE_W-1:0]       hold_data_q, hold_data_d;
  logic [BYTE_W-1:0]       next_char_c;
  logic                    load_c;
  logic                    accept_c;
  logic                    drain_c;

  // Next state, sync counting, holding buffer and next-character selection.
  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    next_char_c = IDLE_CHAR;
    drain_c     = 1'b0;
    accept_c    = bus.valid_in && !hold_full_q;

    case (state_q)
      ST_SYNC: begin
        if (load_c) begin
          if (sync_cnt_q == SYNC_LAST) begin
            state_d = ST_ACTIVE;
          end else begin
            sync_cnt_d = sync_cnt_q + SYNC_CNT_W'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (hold_full_q) begin
          next_char_c = hold_data_q;
          drain_c     = load_c;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase

    // Accept only when empty, drain only when full: never both in one cycle.
    if (accept_c) begin
      hold_full_d = 1'b1;
      hold_data_d = bus.data_in;
    end else if (drain_c) begin
      hold_full_d = 1'b0;
    end
  end

  // Control and holding buffer registers.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_SYNC;
      sync_cnt_q  <= '0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  tx_shift8 u_shift (
    .clk         (clk_32f),
    .rst_n       (reset_L),
    .load_data   (next_char_c),
    .load_c      (load_c),
    .data_out    (data_out),
    .byte_strobe (byte_strobe)
  );

  assign bus.ready_out = !hold_full_q;
  assign sync_done     = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: sync sequence, handshake, idle fill, reset.
module tb_paralelo_serial_tx;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;
  logic data_out;
  logic byte_strobe;
  logic sync_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] bs[4];
  logic [7:0] exp_q[8];
  logic [7:0] c;
  logic       sd;
  logic       rl;
  int         n;

  paralelo_serial_tx_if bus_if ();

  paralelo_serial_tx dut (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .bus         (bus_if.slave),
    .data_out    (data_out),
    .byte_strobe (byte_strobe),
    .sync_done   (sync_done)
  );

  always #5 clk_32f = ~clk_32f;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_32f);
    @(negedge clk_32f);
  endtask

  // Called in the first bit cycle of a character; returns in the next one.
  task automatic recv(output logic [7:0] ch, output logic sd_o, output logic rdy_last);
    ch[7] = data_out;
    sd_o  = sync_done;
    check_eq("strobe_msb", 8'(byte_strobe), 8'h01);
    for (int i = 6; i >= 0; i--) begin
      tick();
      ch[i] = data_out;
      check_eq("strobe_mid", 8'(byte_strobe), 8'h00);
    end
    rdy_last = bus_if.ready_out;
    tick();
  endtask

  task automatic wait_strobe(output int cnt);
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      cnt++;
      if (byte_strobe) break;
    end
  endtask

  task automatic do_reset();
    reset_L          = 1'b0;
    bus_if.valid_in  = 1'b0;
    bus_if.data_in   = 8'h00;
    #1;
    check_eq("rst_data_out", 8'(data_out), 8'h00);
    check_eq("rst_strobe", 8'(byte_strobe), 8'h00);
    check_eq("rst_ready", 8'(bus_if.ready_out), 8'h01);
    check_eq("rst_sync_done", 8'(sync_done), 8'h00);
    @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  // From the release cycle through the N_SYNC commas; optionally offers a byte first.
  task automatic sync_seq(input logic [7:0] pend, input bit has_pend);
    logic [7:0] ch;
    logic       sdv, rdy;
    if (has_pend) begin
      bus_if.data_in  = pend;
      bus_if.valid_in = 1'b1;
    end
    tick();
    bus_if.valid_in = 1'b0;
    if (has_pend) check_eq("rdy_fall", 8'(bus_if.ready_out), 8'h00);
    repeat (6) tick();
    check_eq("pre_load_data", 8'(data_out), 8'h00);
    check_eq("pre_load_strobe", 8'(byte_strobe), 8'h00);
    tick();
    for (int k = 0; k < 4; k++) begin
      recv(ch, sdv, rdy);
      check_eq("comma", ch, 8'hBC);
      check_eq("sync_done_seq", 8'(sdv), 8'(k == 3));
      check_eq("rdy_sync", 8'(rdy), 8'(!has_pend));
    end
    check_eq("rdy_after_sync", 8'(bus_if.ready_out), 8'h01);
  endtask

  task automatic send_bytes(input logic [7:0] b[4], input int cnt, input int gap);
    logic rdy;
    bit   got;
    for (int i = 0; i < cnt; i++) begin
      bus_if.data_in  = b[i];
      bus_if.valid_in = 1'b1;
      rdy = bus_if.ready_out;
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk_32f);
        if (rdy) got = 1'b1;
        else rdy = bus_if.ready_out;
      end
      check_eq("accept_timeout", 8'(got), 8'h01);
      bus_if.valid_in = 1'b0;
      if (gap > 0) begin
        for (int t = 0; t < 40 && !bus_if.ready_out; t++) @(negedge clk_32f);
        repeat (gap) @(negedge clk_32f);
      end
    end
  endtask

  task automatic expect_chars(input logic [7:0] e[8], input int cnt, input string tag);
    logic [7:0] ch;
    logic       sdv, rdy;
    for (int k = 0; k < cnt; k++) begin
      recv(ch, sdv, rdy);
      check_eq(tag, ch, e[k]);
    end
  endtask

  initial begin
    bus_if.valid_in = 1'b0;
    bus_if.data_in  = 8'h00;
    repeat (2) @(negedge clk_32f);

    // Reset then idle: commas, sync_done on the 4th, then idle fill.
    do_reset();
    sync_seq(8'h00, 1'b0);
    recv(c, sd, rl);
    check_eq("idle_after_sync", c, 8'hBC);
    check_eq("sync_done_active", 8'(sd), 8'h01);

    // Back-to-back stream with valid held high.
    bs    = '{8'h01, 8'h02, 8'h03, 8'h00};
    exp_q = '{8'hBC, 8'h01, 8'h02, 8'h03, 8'hBC, 8'h00, 8'h00, 8'h00};
    fork
      send_bytes(bs, 3, 0);
      expect_chars(exp_q, 5, "stream");
    join

    // Accepted on a load edge: loaded 8 cycles later.
    repeat (7) tick();
    bus_if.data_in  = 8'hC3;
    bus_if.valid_in = 1'b1;
    tick();
    bus_if.valid_in = 1'b0;
    check_eq("rdy_after_accept", 8'(bus_if.ready_out), 8'h00);
    wait_strobe(n);
    check_eq("lat_on_load", 8'(n), 8'd8);
    check_eq("rdy_after_drain", 8'(bus_if.ready_out), 8'h01);
    recv(c, sd, rl);
    check_eq("data_c3", c, 8'hC3);

    // Accepted one cycle after a load edge: loaded 7 cycles later.
    bus_if.data_in  = 8'h3C;
    bus_if.valid_in = 1'b1;
    tick();
    bus_if.valid_in = 1'b0;
    wait_strobe(n);
    check_eq("lat_after_load", 8'(n), 8'd7);
    recv(c, sd, rl);
    check_eq("data_3c", c, 8'h3C);

    // 16-cycle gap in valid_in: two idle characters between the bytes.
    bs    = '{8'h5A, 8'h96, 8'h00, 8'h00};
    exp_q = '{8'hBC, 8'h5A, 8'hBC, 8'hBC, 8'h96, 8'hBC, 8'h00, 8'h00};
    fork
      send_bytes(bs, 2, 16);
      expect_chars(exp_q, 6, "gap");
    join

    // Reset mid-character with a byte buffered: byte is discarded.
    bus_if.data_in  = 8'hE7;
    bus_if.valid_in = 1'b1;
    tick();
    bus_if.valid_in = 1'b0;
    tick();
    tick();
    check_eq("hold_before_rst", 8'(bus_if.ready_out), 8'h00);
    do_reset();
    sync_seq(8'h00, 1'b0);
    recv(c, sd, rl);
    check_eq("no_stale_byte", c, 8'hBC);
    recv(c, sd, rl);
    check_eq("no_stale_byte2", c, 8'hBC);

    // Byte offered during SYNC waits for the last comma.
    do_reset();
    sync_seq(8'hA5, 1'b1);
    recv(c, sd, rl);
    check_eq("data_a5", c, 8'hA5);
    check_eq("a5_sync_done", 8'(sd), 8'h01);
    recv(c, sd, rl);
    check_eq("idle_after_a5", c, 8'hBC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
